// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
// The ST_DEC/CHECK states exist only when AES_SELFTEST_EN is defined.
package aes_pkg;

  localparam int MAX_NR = 14;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    HOLD
`ifdef AES_SELFTEST_EN
    ,
    ST_DEC,
    CHECK
`endif
  } state_e;

  typedef enum logic [1:0] {
    KIND_INIT  = 2'd0,
    KIND_MID   = 2'd1,
    KIND_FINAL = 2'd2
  } rnd_kind_e;

  localparam logic [1:0] KEYSEL_128 = 2'b00;
  localparam logic [1:0] KEYSEL_192 = 2'b01;
  localparam logic [1:0] KEYSEL_256 = 2'b10;

  function automatic logic [3:0] nr_for(input logic [1:0] keysel);
    case (keysel)
      KEYSEL_128: nr_for = 4'd10;
      KEYSEL_192: nr_for = 4'd12;
      KEYSEL_256: nr_for = 4'(MAX_NR);
      default:    nr_for = 4'(MAX_NR);
    endcase
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Loadable up/down round-key index counter; term flags count == limit.
module aes_round_counter #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             step,
  input  logic             down,
  input  logic [IDX_W-1:0] limit,
  output logic [IDX_W-1:0] count,
  output logic             term
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step) begin
      count <= down ? count - IDX_W'(1) : count + IDX_W'(1);
    end
  end

  assign term = (count == limit);

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences Nr+1 AES rounds through an external round datapath per job.
// Define AES_SELFTEST_EN to decrypt each ciphertext back and flag st_pass/st_fail.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_keysel,
  input  logic              in_decrypt,
  output logic              rnd_req,
  input  logic              rnd_ack,
  output logic [IDX_W-1:0]  rnd_idx,
  output logic [1:0]        rnd_kind,
  output logic              rnd_inv,
  output logic [DATA_W-1:0] rnd_state,
  input  logic [DATA_W-1:0] rnd_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              st_pass,
  output logic              st_fail
);

  if (DATA_W != 128) begin : g_bad_data_w
    $error("aes_round_sequencer: DATA_W must be 128");
  end
  if ((1 << IDX_W) <= MAX_NR) begin : g_bad_idx_w
    $error("aes_round_sequencer: IDX_W too narrow for MAX_NR");
  end

  state_e            state, state_nx;
  rnd_kind_e         kind;
  logic [IDX_W-1:0]  nr_q;
  logic              dec_q;
  logic [DATA_W-1:0] data_q;
  logic              accept, fire, main_fire;
  logic              cnt_load, cnt_step, cnt_down, cnt_term;
  logic [IDX_W-1:0]  cnt_load_val, cnt_limit;

  assign accept    = in_valid && in_ready;
  assign fire      = rnd_req && rnd_ack;
  assign main_fire = fire && (state inside {INIT, ROUND, FINAL});

  aes_round_counter #(.IDX_W(IDX_W)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .step     (cnt_step),
    .down     (cnt_down),
    .limit    (cnt_limit),
    .count    (rnd_idx),
    .term     (cnt_term)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_nx     = state;
    in_ready     = 1'b0;
    rnd_req      = 1'b0;
    kind         = KIND_INIT;
    rnd_inv      = 1'b0;
    out_valid    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_step     = 1'b0;
    cnt_down     = dec_q;
    // In ROUND, term marks the last middle round (the one before the final index).
    cnt_limit    = dec_q ? IDX_W'(1) : nr_q - IDX_W'(1);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx     = INIT;
          cnt_load     = 1'b1;
          cnt_load_val = in_decrypt ? IDX_W'(nr_for(in_keysel)) : '0;
        end
      end
      INIT: begin
        rnd_req  = 1'b1;
        rnd_inv  = dec_q;
        cnt_step = fire;
        if (fire) state_nx = ROUND;
      end
      ROUND: begin
        rnd_req  = 1'b1;
        kind     = KIND_MID;
        rnd_inv  = dec_q;
        cnt_step = fire;
        if (fire && cnt_term) state_nx = FINAL;
      end
      FINAL: begin
        rnd_req = 1'b1;
        kind    = KIND_FINAL;
        rnd_inv = dec_q;
        if (fire) begin
`ifdef AES_SELFTEST_EN
          if (!dec_q) begin
            state_nx     = ST_DEC;
            cnt_load     = 1'b1;
            cnt_load_val = nr_q;
          end else begin
            state_nx = HOLD;
          end
`else
          state_nx = HOLD;
`endif
        end
      end
`ifdef AES_SELFTEST_EN
      ST_DEC: begin
        rnd_req   = 1'b1;
        rnd_inv   = 1'b1;
        cnt_down  = 1'b1;
        cnt_limit = '0;
        cnt_step  = fire;
        if (rnd_idx == nr_q) kind = KIND_INIT;
        else if (cnt_term)   kind = KIND_FINAL;
        else                 kind = KIND_MID;
        if (fire && cnt_term) state_nx = CHECK;
      end
      CHECK: state_nx = HOLD;
`endif
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state  <= IDLE;
      nr_q   <= '0;
      dec_q  <= 1'b0;
      // NOTE: the data register is reset as well, so out_data reads 0 after reset.
      data_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        nr_q   <= IDX_W'(nr_for(in_keysel));
        dec_q  <= in_decrypt;
        data_q <= in_data;
      end else if (main_fire) begin
        data_q <= rnd_result;
      end
    end
  end

  assign rnd_kind = kind;
  assign out_data = data_q;
  assign busy     = (state != IDLE);

`ifdef AES_SELFTEST_EN
  logic [DATA_W-1:0] save_q, st_q;
  logic              pass_q, fail_q;

  // The self-test decrypts in its own register so out_data keeps the ciphertext.
  always_ff @(posedge clk) begin
    if (reset) begin
      save_q <= '0;
      st_q   <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      if (accept) begin
        save_q <= in_data;
        pass_q <= 1'b0;
        fail_q <= 1'b0;
      end
      if (fire && (state == FINAL || state == ST_DEC)) st_q <= rnd_result;
      if (state == CHECK) begin
        pass_q <= (st_q == save_q);
        fail_q <= (st_q != save_q);
      end
    end
  end

  assign rnd_state = (state == ST_DEC) ? st_q : data_q;
  assign st_pass   = pass_q;
  assign st_fail   = fail_q;
`else
  assign rnd_state = data_q;
  assign st_pass   = 1'b0;
  assign st_fail   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a behavioural AES round model;
// self-test expectations switch on AES_SELFTEST_EN.
module tb_aes_round_sequencer;

`ifdef AES_SELFTEST_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_decrypt;
  logic [127:0] in_data;
  logic [1:0]   in_keysel;
  logic         rnd_req, rnd_ack, rnd_inv;
  logic [3:0]   rnd_idx;
  logic [1:0]   rnd_kind;
  logic [127:0] rnd_state, rnd_result;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         busy, st_pass, st_fail;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb[256];
  logic [7:0]  isb[256];
  logic [31:0] w[60];
  bit          ack_tied = 1'b0;
  bit          corrupt  = 1'b0;
  logic [3:0]  log_idx[64];
  logic [1:0]  log_kind[64];
  logic        log_inv[64];
  int          log_n = 0;

  aes_round_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_keysel  (in_keysel),
    .in_decrypt (in_decrypt),
    .rnd_req    (rnd_req),
    .rnd_ack    (rnd_ack),
    .rnd_idx    (rnd_idx),
    .rnd_kind   (rnd_kind),
    .rnd_inv    (rnd_inv),
    .rnd_state  (rnd_state),
    .rnd_result (rnd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .st_pass    (st_pass),
    .st_fail    (st_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] r, p, x;
    logic [7:0] e;
    r = 8'h01; p = a; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    x = r;
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [7:0]   a[16];
    logic [7:0]   m[4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - r + 4) % 4], a[k + 4*c]);
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  // Forward: Sub, Shift, [Mix], AddKey.  Inverse: InvShift, InvSub, AddKey, [InvMix].
  function automatic logic [127:0] aes_round(input logic [127:0] s, input int idx,
                                             input logic [1:0] kind, input logic inv);
    logic [7:0]   a[16];
    logic [7:0]   b[16];
    logic [127:0] rk, t;
    rk = {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    if (kind == 2'd0) return s ^ rk;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r+4*c] = inv ? isb[a[r + 4*((c - r + 4) % 4)]] : sb[a[r + 4*((c + r) % 4)]];
    t = '0;
    for (int i = 0; i < 16; i++) t[127-8*i -: 8] = b[i];
    if (!inv) begin
      if (kind == 2'd1) t = mix_cols(t, 1'b0);
      return t ^ rk;
    end
    t = t ^ rk;
    if (kind == 2'd1) t = mix_cols(t, 1'b1);
    return t;
  endfunction

  // Round datapath model: answers on the negedge, so ack is seen at the next rising edge.
  initial begin
    rnd_ack    = 1'b0;
    rnd_result = '0;
    forever begin
      @(negedge clk);
      if (rnd_req && (ack_tied || !rnd_ack)) begin
        if (log_n < 64) begin
          log_idx[log_n]  = rnd_idx;
          log_kind[log_n] = rnd_kind;
          log_inv[log_n]  = rnd_inv;
        end
        log_n++;
        rnd_result = aes_round(rnd_state, int'(rnd_idx), rnd_kind, rnd_inv);
        if (corrupt && rnd_inv && rnd_kind == 2'd1) rnd_result[0] = ~rnd_result[0];
        rnd_ack = 1'b1;
      end else begin
        rnd_ack = ack_tied;
      end
    end
  end

  // ---------------- job helpers (called at a negedge with the DUT idle) ----------------
  task automatic do_job(input logic [1:0] ks, input logic dec, input logic [127:0] din,
                        input bit toggle, output int lat, output logic [127:0] dout);
    log_n      = 0;
    in_keysel  = ks;
    in_decrypt = dec;
    in_data    = din;
    in_valid   = 1'b1;
    check("in_ready_before_accept", 128'(in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~din;
    lat      = 1;
    for (int i = 0; i < 400 && !out_valid; i++) begin
      if (toggle) begin
        in_keysel  = in_keysel + 2'd1;
        in_decrypt = ~in_decrypt;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("out_valid_rise", 128'(out_valid), 128'(1));
    dout = out_data;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_transfer", 128'(in_ready), 128'(1));
    check("out_valid_after_transfer", 128'(out_valid), 128'(0));
    check("busy_after_transfer", 128'(busy), 128'(0));
  endtask

  task automatic check_rounds(input int nr, input logic dec);
    int exp_n;
    exp_n = (ST && !dec) ? 2 * (nr + 1) : nr + 1;
    check("round_count", 128'(log_n), 128'(exp_n));
    for (int i = 0; i <= nr; i++) begin
      check($sformatf("rnd_idx[%0d]", i), 128'(log_idx[i]), 128'(dec ? nr - i : i));
      check($sformatf("rnd_kind[%0d]", i), 128'(log_kind[i]),
            128'((i == 0) ? 0 : (i == nr) ? 2 : 1));
      check($sformatf("rnd_inv[%0d]", i), 128'(log_inv[i]), 128'(dec));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int           lat;
    logic [127:0] dout;
    bit           seen;

    for (int i = 0; i < 256; i++) begin
      sb[i]      = sbox_calc(8'(i));
      isb[sb[i]] = 8'(i);
    end

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_keysel  = 2'b00;
    in_decrypt = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_rnd_req", 128'(rnd_req), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_st_pass", 128'(st_pass), 128'(0));
    check("rst_st_fail", 128'(st_fail), 128'(0));
    check("rst_rnd_idx", 128'(rnd_idx), 128'(0));
    check("rst_rnd_kind", 128'(rnd_kind), 128'(0));
    check("rst_rnd_inv", 128'(rnd_inv), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // AES-128 encrypt, FIPS-197 C.1
    expand_key(KEY128, 4);
    do_job(2'b00, 1'b0, PT, 1'b0, lat, dout);
    check("aes128_enc_data", dout, CT128);
    check_rounds(10, 1'b0);
    check("aes128_st_pass", 128'(st_pass), 128'(ST));
    check("aes128_st_fail", 128'(st_fail), 128'(0));
    take_output();

    // AES-256 decrypt, FIPS-197 C.3
    expand_key(KEY256, 8);
    do_job(2'b10, 1'b1, CT256, 1'b0, lat, dout);
    check("aes256_dec_data", dout, PT);
    check_rounds(14, 1'b1);
    check("aes256_st_pass", 128'(st_pass), 128'(0));
    check("aes256_st_fail", 128'(st_fail), 128'(0));
    take_output();

    // AES-192 encrypt with rnd_ack tied high: exact latency, then back-pressure in HOLD
    ack_tied = 1'b1;
    expand_key(KEY192, 6);
    do_job(2'b01, 1'b0, PT, 1'b0, lat, dout);
    check("aes192_latency", 128'(lat), 128'(ST ? 28 : 14));
    check("aes192_enc_data", dout, CT192);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold_out_data[%0d]", i), out_data, CT192);
      check($sformatf("hold_out_valid[%0d]", i), 128'(out_valid), 128'(1));
      check($sformatf("hold_in_ready[%0d]", i), 128'(in_ready), 128'(0));
    end
    take_output();
    ack_tied = 1'b0;

    // Reset while round 6 is in flight, then a fresh job
    expand_key(KEY128, 4);
    @(negedge clk);
    in_keysel  = 2'b00;
    in_decrypt = 1'b0;
    in_data    = PT;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !(rnd_req && rnd_idx == 4'd6); i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("reached_round6", 128'(rnd_idx), 128'(6));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_rnd_req", 128'(rnd_req), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", 128'(seen), 128'(0));
    do_job(2'b00, 1'b0, PT, 1'b0, lat, dout);
    check("post_abort_data", dout, CT128);
    take_output();

    // in_keysel / in_decrypt toggled mid-job are ignored; next accept uses the new keysel
    do_job(2'b00, 1'b0, PT, 1'b1, lat, dout);
    check("toggle_data", dout, CT128);
    check_rounds(10, 1'b0);
    take_output();
    expand_key(KEY192, 6);
    do_job(2'b01, 1'b0, PT, 1'b0, lat, dout);
    check("next_keysel_data", dout, CT192);
    check_rounds(12, 1'b0);
    take_output();

`ifdef AES_SELFTEST_EN
    // Self-test: clean pass with exact latency, then a corrupted inverse round
    ack_tied = 1'b1;
    expand_key(KEY128, 4);
    do_job(2'b00, 1'b0, PT, 1'b0, lat, dout);
    check("st_latency", 128'(lat), 128'(24));
    check("st_data", dout, CT128);
    check("st_pass_clean", 128'(st_pass), 128'(1));
    check("st_fail_clean", 128'(st_fail), 128'(0));
    take_output();
    corrupt = 1'b1;
    do_job(2'b00, 1'b0, PT, 1'b0, lat, dout);
    check("st_corrupt_data", dout, CT128);
    check("st_pass_corrupt", 128'(st_pass), 128'(0));
    check("st_fail_corrupt", 128'(st_fail), 128'(1));
    take_output();
    corrupt  = 1'b0;
    ack_tied = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
